level_sequencer: RTL and testbench
==================================

# level_sequencer

Parametrised multi-level game controller for the GoldMiner stage pipeline. Streams each level's object table out of an external synchronous ROM, tracks which objects are still on the field, accumulates score from hook grabs, runs the countdown timer and decides pass/fail against a per-level target. It sits between the stage FSM (which supplies `enable`) and the object/hook/time-display renderers, which consume its registered table and counters.

## Interface
Parameters:
- LEVEL_COUNT, 4, number of levels stored in ROM
- OBJECTS_COUNT, 20, object slots per level (3 ROM words each: X, Y, type)
- COORD_W, 9, ROM word / coordinate / type width
- TIME_INIT, 83, seconds per level
- SCORE_W, 16, score width (saturating)
- TARGET_BASE, 100; TARGET_STEP, 50: level L target = TARGET_BASE + L*TARGET_STEP

Ports (IDX_W = clog2(OBJECTS_COUNT), LVL_W = clog2(LEVEL_COUNT), AW = clog2(LEVEL_COUNT*OBJECTS_COUNT*3)):
- clk  in  1  system clock
- resetN  in  1  reset, asynchronous, active-low
- enable  in  1  level run request from stage FSM
- pause  in  1  freezes timer while high
- oneSecPulse  in  1  one-cycle 1 Hz tick
- grabValid  in  1  one-cycle grab event from hook
- grabIndex  in  IDX_W  slot grabbed
- grabValue  in  SCORE_W  value added on valid grab
- romAddr  out  AW  ROM read address
- romData  in  COORD_W  ROM data, valid one cycle after romAddr
- objX, objY, objType  out  OBJECTS_COUNT*COORD_W  flat tables, slot i at [i*COORD_W +: COORD_W]
- objPresent  out  OBJECTS_COUNT  slot still on field
- timer  out  9  seconds remaining
- score  out  SCORE_W  current-level score
- level  out  LVL_W  current level index
- loading  out  1  high in LOAD
- stagePassed, stageFailed  out  1  one-cycle result pulses
- lastLevelEnded  out  1  sticky, set on passing level LEVEL_COUNT-1

## Operation
- States IDLE, LOAD, PLAY, DONE. Reset: IDLE, all outputs 0 except timer = TIME_INIT; tables 0.
- IDLE: rising edge of enable (enable & !enable_d) -> LOAD; romAddr = level*OBJECTS_COUNT*3, word counter k = 0. If lastLevelEnded, stay IDLE.
- LOAD: romAddr increments each cycle; word arriving in cycle k+1 written to slot k/3, field k%3 (0=X, 1=Y, 2=type). On type write, objPresent[slot] = (type != 0). After last word: timer = TIME_INIT, score = 0, -> PLAY.
- PLAY:
  - grabValid with grabIndex < OBJECTS_COUNT and objPresent[grabIndex]=1: clear bit, score = min(score+grabValue, 2^SCORE_W-1). Otherwise ignored.
  - oneSecPulse & !pause: timer -= 1. Pulse with timer==0 (never underflows), or objPresent all-zero: end level.
  - End: score >= target -> stagePassed; level+1 unless last level, then lastLevelEnded=1, level held. Else stageFailed, level unchanged. -> DONE.
- DONE: enable low -> IDLE (new level requires re-assertion).
- enable low in LOAD or PLAY: abort -> IDLE, no pulse, level/score held.
- Grab and end condition in same cycle: grab counted first; pass/fail uses updated score.

## Timing
- LOAD duration exactly OBJECTS_COUNT*3+1 cycles from entry; loading high throughout.
- Edge detect adds 1 cycle: LOAD entered the cycle after enable's rising edge is sampled.
- All outputs registered; score/objPresent update the cycle after grabValid.
- Result pulse appears the cycle after the ending condition; exactly one per level.
- timer reaches 0 one pulse before expiry; expiry on the following pulse (TIME_INIT+1 pulses total).

## Test plan
- Reset mid-PLAY: resetN low -> state IDLE, level 0, timer 83, score 0, tables 0 asynchronously.
- Load level 1 (ROM word n = n): rise enable -> loading 61 cycles, romAddr 60..119, slot 0 = X 60, Y 61, type 62; type-0 slots not present.
- Grab slot 3 value 40 twice -> score 40, second grab ignored; grabIndex 25 ignored.
- No grabs, 84 oneSecPulses -> stageFailed once, level unchanged; pause high masks pulses.
- Grab all present slots, total 150 on level 0 -> early end, stagePassed, level 1; same cycle as final tick -> still pass.
- Pass level 3 -> lastLevelEnded=1, level stays 3; further enable edges ignored; enable drop in LOAD -> IDLE without pulse.

Source files
------------

// File: rtl/level_sequencer_if.sv
// Bus between level_sequencer and its neighbours: stage FSM controls, hook grabs,
// object ROM port and the registered tables/counters read by the renderers.
interface level_sequencer_if #(
  parameter int LEVEL_COUNT   = 4,
  parameter int OBJECTS_COUNT = 20,
  parameter int COORD_W       = 9,
  parameter int SCORE_W       = 16
);
  localparam int IDX_W = (OBJECTS_COUNT > 1) ? $clog2(OBJECTS_COUNT) : 1;
  localparam int LVL_W = (LEVEL_COUNT > 1) ? $clog2(LEVEL_COUNT) : 1;
  localparam int AW    = $clog2(LEVEL_COUNT * OBJECTS_COUNT * 3);

  logic                             enable;
  logic                             pause;
  logic                             oneSecPulse;
  logic                             grabValid;
  logic [IDX_W-1:0]                 grabIndex;
  logic [SCORE_W-1:0]               grabValue;
  logic [AW-1:0]                    romAddr;
  logic [COORD_W-1:0]               romData;
  logic [OBJECTS_COUNT*COORD_W-1:0] objX;
  logic [OBJECTS_COUNT*COORD_W-1:0] objY;
  logic [OBJECTS_COUNT*COORD_W-1:0] objType;
  logic [OBJECTS_COUNT-1:0]         objPresent;
  logic [8:0]                       timer;
  logic [SCORE_W-1:0]               score;
  logic [LVL_W-1:0]                 level;
  logic                             loading;
  logic                             stagePassed;
  logic                             stageFailed;
  logic                             lastLevelEnded;

  modport master (
    output enable, pause, oneSecPulse, grabValid, grabIndex, grabValue, romData,
    input  romAddr, objX, objY, objType, objPresent, timer, score, level,
           loading, stagePassed, stageFailed, lastLevelEnded
  );

  modport slave (
    input  enable, pause, oneSecPulse, grabValid, grabIndex, grabValue, romData,
    output romAddr, objX, objY, objType, objPresent, timer, score, level,
           loading, stagePassed, stageFailed, lastLevelEnded
  );
endinterface

// File: rtl/level_sequencer.sv
// GoldMiner level controller: streams a level's object table from ROM, scores hook
// grabs, runs the countdown and reports pass/fail against the per-level target.
module level_sequencer #(
  parameter int LEVEL_COUNT   = 4,
  parameter int OBJECTS_COUNT = 20,
  parameter int COORD_W       = 9,
  parameter int TIME_INIT     = 83,
  parameter int SCORE_W       = 16,
  parameter int TARGET_BASE   = 100,
  parameter int TARGET_STEP   = 50
) (
  input logic           clk,
  input logic           resetN,
  level_sequencer_if.slave bus
);
  localparam int IDX_W = (OBJECTS_COUNT > 1) ? $clog2(OBJECTS_COUNT) : 1;
  localparam int LVL_W = (LEVEL_COUNT > 1) ? $clog2(LEVEL_COUNT) : 1;
  localparam int WORDS = OBJECTS_COUNT * 3;
  localparam int AW    = $clog2(LEVEL_COUNT * WORDS);
  localparam int CNT_W = $clog2(WORDS + 1);

  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(WORDS);
  localparam logic [CNT_W-1:0] CNT_ADDR_END = CNT_W'(WORDS - 1);
  localparam logic [8:0]       TIMER_INIT   = 9'(TIME_INIT);
  localparam logic [LVL_W-1:0] LVL_LAST     = LVL_W'(LEVEL_COUNT - 1);
  localparam logic [IDX_W:0]   SLOTS        = (IDX_W+1)'(OBJECTS_COUNT);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, DONE} state_t;

  state_t                                  state_q, state_d;
  logic                                    en_q;
  logic [CNT_W-1:0]                        cnt_q, cnt_d;
  logic [IDX_W-1:0]                        slot_q, slot_d;
  logic [1:0]                              fld_q, fld_d;
  logic [AW-1:0]                           addr_q, addr_d;
  logic [8:0]                              timer_q, timer_d;
  logic [SCORE_W-1:0]                      score_q, score_d;
  logic [LVL_W-1:0]                        level_q, level_d;
  logic [OBJECTS_COUNT-1:0]                pres_q, pres_d;
  logic                                    loading_q, loading_d;
  logic                                    pass_q, pass_d;
  logic                                    fail_q, fail_d;
  logic                                    last_q, last_d;
  logic [OBJECTS_COUNT-1:0][COORD_W-1:0]   x_q, y_q, t_q;

  logic               wr_en;
  logic               end_lvl;
  logic               rise;
  logic [SCORE_W:0]   sum;
  logic [31:0]        tgt;

  assign rise = bus.enable & ~en_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    slot_d    = slot_q;
    fld_d     = fld_q;
    addr_d    = addr_q;
    timer_d   = timer_q;
    score_d   = score_q;
    level_d   = level_q;
    pres_d    = pres_q;
    last_d    = last_q;
    loading_d = 1'b0;
    pass_d    = 1'b0;
    fail_d    = 1'b0;
    wr_en     = 1'b0;
    end_lvl   = 1'b0;
    sum       = {1'b0, score_q} + {1'b0, bus.grabValue};
    tgt       = 32'(TARGET_BASE) + 32'(level_q) * 32'(TARGET_STEP);

    case (state_q)
      IDLE: begin
        if (rise && !last_q) begin
          state_d   = LOAD;
          loading_d = 1'b1;
          addr_d    = AW'(32'(level_q) * 32'(WORDS));
          cnt_d     = '0;
          slot_d    = '0;
          fld_d     = '0;
          pres_d    = '0;
        end
      end
      LOAD: begin
        if (!bus.enable) begin
          state_d = IDLE;
        end else begin
          loading_d = 1'b1;
          // ROM is one cycle behind the address, so word k lands in LOAD cycle k+1
          if (cnt_q != '0) begin
            wr_en = 1'b1;
            if (fld_q == 2'd2) begin
              pres_d[slot_q] = |bus.romData;
              fld_d          = 2'd0;
              slot_d         = slot_q + IDX_W'(1);
            end else begin
              fld_d = fld_q + 2'd1;
            end
          end
          if (cnt_q < CNT_ADDR_END) addr_d = addr_q + AW'(1);
          if (cnt_q == CNT_LAST) begin
            state_d   = PLAY;
            loading_d = 1'b0;
            timer_d   = TIMER_INIT;
            score_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      PLAY: begin
        if (!bus.enable) begin
          state_d = IDLE;
        end else begin
          if (bus.grabValid && ({1'b0, bus.grabIndex} < SLOTS) && pres_q[bus.grabIndex]) begin
            pres_d[bus.grabIndex] = 1'b0;
            score_d = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
          end
          if (bus.oneSecPulse && !bus.pause) begin
            if (timer_q == '0) end_lvl = 1'b1;
            else timer_d = timer_q - 9'd1;
          end
          if (pres_d == '0) end_lvl = 1'b1;
          // judged on the post-grab score so a grab coinciding with expiry counts
          if (end_lvl) begin
            state_d = DONE;
            if (32'(score_d) >= tgt) begin
              pass_d = 1'b1;
              if (level_q == LVL_LAST) last_d = 1'b1;
              else level_d = level_q + LVL_W'(1);
            end else begin
              fail_d = 1'b1;
            end
          end
        end
      end
      DONE: begin
        if (!bus.enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= IDLE;
      en_q      <= 1'b0;
      cnt_q     <= '0;
      slot_q    <= '0;
      fld_q     <= '0;
      addr_q    <= '0;
      timer_q   <= TIMER_INIT;
      score_q   <= '0;
      level_q   <= '0;
      pres_q    <= '0;
      loading_q <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_q      <= bus.enable;
      cnt_q     <= cnt_d;
      slot_q    <= slot_d;
      fld_q     <= fld_d;
      addr_q    <= addr_d;
      timer_q   <= timer_d;
      score_q   <= score_d;
      level_q   <= level_d;
      pres_q    <= pres_d;
      loading_q <= loading_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      last_q    <= last_d;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      x_q <= '0;
      y_q <= '0;
      t_q <= '0;
    end else if (wr_en) begin
      case (fld_q)
        2'd0:    x_q[slot_q] <= bus.romData;
        2'd1:    y_q[slot_q] <= bus.romData;
        default: t_q[slot_q] <= bus.romData;
      endcase
    end
  end

  assign bus.romAddr        = addr_q;
  assign bus.objX           = x_q;
  assign bus.objY           = y_q;
  assign bus.objType        = t_q;
  assign bus.objPresent     = pres_q;
  assign bus.timer          = timer_q;
  assign bus.score          = score_q;
  assign bus.level          = level_q;
  assign bus.loading        = loading_q;
  assign bus.stagePassed    = pass_q;
  assign bus.stageFailed    = fail_q;
  assign bus.lastLevelEnded = last_q;
endmodule

// File: tb/tb_level_sequencer.sv
// Bench for level_sequencer: transaction-level game model feeds a result scoreboard
// that a negedge monitor drains on every stagePassed/stageFailed pulse.
module tb_level_sequencer;
  localparam int LC = 4, OC = 20, CW = 9, TI = 83, SW = 16, TBASE = 100, TSTEP = 50;
  localparam int WORDS = OC * 3;
  localparam int SMAX  = (1 << SW) - 1;

  typedef struct { bit pass; int level; int score; bit last; } res_t;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  level_sequencer_if #(.LEVEL_COUNT(LC), .OBJECTS_COUNT(OC), .COORD_W(CW), .SCORE_W(SW)) bus ();

  level_sequencer #(
    .LEVEL_COUNT(LC), .OBJECTS_COUNT(OC), .COORD_W(CW), .TIME_INIT(TI),
    .SCORE_W(SW), .TARGET_BASE(TBASE), .TARGET_STEP(TSTEP)
  ) dut (.clk(clk), .resetN(resetN), .bus(bus));

  logic [CW-1:0] rom [LC*WORDS];
  always @(posedge clk) bus.romData <= rom[bus.romAddr];

  int total = 0;
  int bad   = 0;

  // reference game state
  int       m_level = 0;
  bit       m_last = 0;
  bit       m_playing = 0;
  bit [OC-1:0] m_pres = '0;
  int       m_score = 0;
  int       m_timer = TI;
  res_t     expq[$];
  int       plist[$];

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (resetN && (bus.stagePassed || bus.stageFailed)) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: passed=%0b failed=%0b with nothing expected",
                 bus.stagePassed, bus.stageFailed);
      end else begin
        res_t e;
        e = expq.pop_front();
        chk("res_pass", int'(bus.stagePassed), int'(e.pass));
        chk("res_fail", int'(bus.stageFailed), int'(!e.pass));
        chk("res_level", int'(bus.level), e.level);
        chk("res_score", int'(bus.score), e.score);
        chk("res_last", int'(bus.lastLevelEnded), int'(e.last));
      end
    end
  end

  function automatic void model_end();
    res_t r;
    r.pass = (m_score >= TBASE + m_level * TSTEP);
    if (r.pass) begin
      if (m_level == LC - 1) m_last = 1'b1;
      else m_level++;
    end
    r.level = m_level;
    r.score = m_score;
    r.last  = m_last;
    expq.push_back(r);
    m_playing = 1'b0;
  endfunction

  function automatic void build_plist();
    plist.delete();
    for (int i = 0; i < OC; i++) if (m_pres[i]) plist.push_back(i);
  endfunction

  // one cycle of hook/timer activity, driven at negedge and checked at the next
  task automatic act(bit g, int idx, int val, bit p, bit pz);
    bit e;
    e = 1'b0;
    bus.grabValid   = g;
    bus.grabIndex   = idx[4:0];
    bus.grabValue   = val[SW-1:0];
    bus.oneSecPulse = p;
    bus.pause       = pz;
    if (m_playing) begin
      if (g && idx < OC && m_pres[idx]) begin
        m_pres[idx] = 1'b0;
        m_score = (m_score + val > SMAX) ? SMAX : m_score + val;
      end
      if (p && !pz) begin
        if (m_timer == 0) e = 1'b1;
        else m_timer--;
      end
      if (m_pres == '0) e = 1'b1;
      if (e) model_end();
    end
    @(negedge clk);
    bus.grabValid   = 1'b0;
    bus.oneSecPulse = 1'b0;
    bus.pause       = 1'b0;
    if (g) begin
      chk("score", int'(bus.score), m_score);
      chk("present", int'(bus.objPresent), int'(m_pres));
    end
    if (p) chk("timer", int'(bus.timer), m_timer);
  endtask

  task automatic start_level();
    int n, c, base, bx, by, bt;
    logic [OC*CW-1:0] fx, fy, ft;
    bit addr_ok;
    n = 0; c = 0; bx = 0; by = 0; bt = 0; addr_ok = 1'b1;
    base = m_level * WORDS;
    bus.enable = 1'b0;
    @(negedge clk);
    bus.enable = 1'b1;
    while (!bus.loading && n < 10) begin @(negedge clk); n++; end
    chk("load_start_timeout", int'(n < 10), 1);
    while (bus.loading && c < 100) begin
      if (int'(bus.romAddr) != base + ((c < WORDS - 1) ? c : WORDS - 1)) addr_ok = 1'b0;
      c++;
      @(negedge clk);
    end
    chk("load_cycles", c, WORDS + 1);
    chk("rom_addr_seq", int'(addr_ok), 1);
    m_pres = '0;
    for (int i = 0; i < OC; i++) m_pres[i] = (rom[base + 3*i + 2] != '0);
    m_score = 0; m_timer = TI; m_playing = 1'b1;
    fx = bus.objX; fy = bus.objY; ft = bus.objType;
    for (int i = 0; i < OC; i++) begin
      if (fx[i*CW +: CW] != rom[base + 3*i])     bx++;
      if (fy[i*CW +: CW] != rom[base + 3*i + 1]) by++;
      if (ft[i*CW +: CW] != rom[base + 3*i + 2]) bt++;
    end
    chk("tbl_x_errs", bx, 0);
    chk("tbl_y_errs", by, 0);
    chk("tbl_type_errs", bt, 0);
    chk("slot0_x", int'(fx[CW-1:0]), base);
    chk("load_present", int'(bus.objPresent), int'(m_pres));
    chk("load_timer", int'(bus.timer), TI);
    chk("load_score", int'(bus.score), 0);
  endtask

  // grab every remaining present slot in random order; first grab carries val
  task automatic grab_all(int val);
    int j, s, v;
    v = val;
    build_plist();
    while (plist.size() > 0) begin
      j = $urandom_range(0, plist.size() - 1);
      s = plist[j];
      plist.delete(j);
      act(1'b1, s, v, 1'b0, 1'b0);
      v = 0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, gsel;
    for (int l = 0; l < LC; l++)
      for (int s = 0; s < OC; s++) begin
        int b;
        b = l * WORDS + 3 * s;
        rom[b]     = CW'(b);
        rom[b + 1] = CW'(b + 1);
        rom[b + 2] = ($urandom_range(0, 3) == 0 && s != 0 && s != 3 && s != 5) ? '0 : CW'(b + 2);
      end
    bus.enable = 1'b0; bus.pause = 1'b0; bus.oneSecPulse = 1'b0;
    bus.grabValid = 1'b0; bus.grabIndex = '0; bus.grabValue = '0;

    // reset state
    @(negedge clk); @(negedge clk);
    chk("rst_level", int'(bus.level), 0);
    chk("rst_timer", int'(bus.timer), TI);
    chk("rst_score", int'(bus.score), 0);
    chk("rst_loading", int'(bus.loading), 0);
    chk("rst_pass", int'(bus.stagePassed), 0);
    chk("rst_fail", int'(bus.stageFailed), 0);
    chk("rst_last", int'(bus.lastLevelEnded), 0);
    chk("rst_present", int'(bus.objPresent), 0);
    chk("rst_romaddr", int'(bus.romAddr), 0);
    resetN = 1'b1;
    @(negedge clk);

    // random play on level 0, then asynchronous reset mid-level
    start_level();
    for (int i = 0; i < 20; i++) begin
      gsel = $urandom_range(0, 24);
      act(1'($urandom_range(0, 1)), gsel, $urandom_range(0, 60),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    #2;
    resetN = 1'b0;
    bus.enable = 1'b0;
    #1;
    chk("arst_level", int'(bus.level), 0);
    chk("arst_timer", int'(bus.timer), TI);
    chk("arst_score", int'(bus.score), 0);
    chk("arst_present", int'(bus.objPresent), 0);
    chk("arst_objx", int'(bus.objX[CW-1:0]), 0);
    chk("arst_loading", int'(bus.loading), 0);
    m_level = 0; m_last = 1'b0; m_playing = 1'b0; m_pres = '0; m_score = 0; m_timer = TI;
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);

    // level 0: duplicate and out-of-range grabs, then time out with pause masking
    start_level();
    act(1'b1, 3, 40, 1'b0, 1'b0);
    act(1'b1, 3, 40, 1'b0, 1'b0);
    act(1'b1, 25, 7, 1'b0, 1'b0);
    chk("dup_grab_score", int'(bus.score), 40);
    for (int i = 0; i < TI + 1; i++) begin
      if (i % 10 == 5) act(1'b0, 0, 0, 1'b1, 1'b1);
      act(1'b0, 0, 0, 1'b1, 1'b0);
    end
    chk("fail_level_held", int'(bus.level), 0);

    // level 0: clear the field early for a pass
    start_level();
    grab_all(150);
    chk("early_pass_level", int'(bus.level), 1);

    // level 1: final grab lands on the expiring tick
    start_level();
    build_plist();
    n = plist.size();
    act(1'b1, plist[0], 140, 1'b0, 1'b0);
    for (int i = 1; i < n - 2; i++) act(1'b1, plist[i], 0, 1'b0, 1'b0);
    for (int i = 0; i < TI; i++) act(1'b0, 0, 0, 1'b1, 1'b0);
    chk("timer_zero", int'(bus.timer), 0);
    act(1'b1, plist[n-2], 20, 1'b1, 1'b0);
    chk("tie_pass_level", int'(bus.level), 2);

    // level 2: score saturation
    start_level();
    build_plist();
    act(1'b1, plist[0], 65000, 1'b0, 1'b0);
    act(1'b1, plist[1], 65000, 1'b0, 1'b0);
    grab_all(1);

    // level 3: abort during LOAD, then pass the final level
    bus.enable = 1'b0;
    @(negedge clk);
    bus.enable = 1'b1;
    n = 0;
    while (!bus.loading && n < 10) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    bus.enable = 1'b0;
    @(negedge clk);
    chk("abort_loading", int'(bus.loading), 0);
    chk("abort_level", int'(bus.level), 3);
    repeat (3) @(negedge clk);
    start_level();
    grab_all(300);
    chk("last_level_hold", int'(bus.level), 3);
    chk("last_sticky", int'(bus.lastLevelEnded), 1);

    // further enable edges are ignored once the game is finished
    bus.enable = 1'b0;
    @(negedge clk);
    bus.enable = 1'b1;
    n = 0;
    repeat (6) begin @(negedge clk); if (bus.loading) n++; end
    chk("post_last_no_load", n, 0);
    bus.enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
